light_ramp_ctrl: RTL

LIGHT_RAMP_CTRL -- requirements
Module: light_ramp_ctrl

---
 rtl/light_pkg.sv | 38 +++
 rtl/light_ramp_ctrl_step_ticker.sv | 40 ++++
 rtl/light_ramp_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/light_pkg.sv
// ============================================================================
// Module  : light_pkg
// Purpose : Shared types, sizes and helpers for the lamp/shade ramp controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package light_pkg;

  localparam int NUM_LAMPS        = 16;
  localparam int STEP_DIV_DEFAULT = 8;
  localparam int CNT_W            = $clog2(NUM_LAMPS + 1);
  localparam int SHADE_W          = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Requested lamp counts above the lamp total clamp to "all lamps lit".
  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] n);
    logic [CNT_W-1:0] res;
    res = (n > CNT_W'(NUM_LAMPS)) ? CNT_W'(NUM_LAMPS) : n;
    return res;
  endfunction

  function automatic logic [NUM_LAMPS-1:0] therm(input logic [CNT_W-1:0] n);
    logic [NUM_LAMPS-1:0] res;
    for (int i = 0; i < NUM_LAMPS; i++) begin
      res[i] = (i < int'(n));
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/light_ramp_ctrl_step_ticker.sv
// ============================================================================
// Module  : step_ticker
// Purpose : Ramp-step prescaler; emits a one-cycle tick every STEP_DIV enabled
//           cycles, restartable by a synchronous clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module step_ticker #(
  parameter int STEP_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = $clog2(STEP_DIV);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(STEP_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en & ~i_clr & w_wrap;

endmodule

`default_nettype wire

// File: rtl/light_ramp_ctrl.sv
// ============================================================================
// Module  : light_ramp_ctrl
// Purpose : Ramps a thermometer-coded lamp bank and a window shade toward
//           latched targets, one step per STEP_DIV clocks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module light_ramp_ctrl
  import light_pkg::*;
#(
  parameter int STEP_DIV = STEP_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           tcode,
  input  logic [CNT_W-1:0]     target_num,
  input  logic [SHADE_W-1:0]   target_shade,
  input  logic                 upd_req,
  output logic                 upd_ack,
  output logic [NUM_LAMPS-1:0] lightstate,
  output logic [SHADE_W-1:0]   shade_pos,
  output logic                 busy,
  output logic                 done,
  output logic                 tcode_err
);

  state_t               r_state;
  state_t               w_next;
  logic                 w_load;
  logic                 w_tick;
  logic                 w_at_target;
  logic                 w_step;
  logic                 w_tcode_chg;
  logic                 w_tcode_legal;

  logic [CNT_W-1:0]     r_count;
  logic [SHADE_W-1:0]   r_shade;
  logic [CNT_W-1:0]     r_tgt_num;
  logic [SHADE_W-1:0]   r_tgt_shade;
  logic                 r_ack;
  logic                 r_pending;
  logic [3:0]           r_tcode_q;
  logic                 r_tcode_err;

  assign w_tcode_chg   = (tcode != r_tcode_q);
  assign w_tcode_legal = $onehot0(tcode);
  assign w_at_target   = (r_count == r_tgt_num) && (r_shade == r_tgt_shade);
  assign w_step        = (r_state == ST_RAMP) && w_tick && !w_at_target;

  step_ticker #(
    .STEP_DIV (STEP_DIV)
  ) u_step_ticker (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (r_state == ST_RAMP),
    .i_clr  (w_load),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (upd_req || r_pending) begin
          w_load = 1'b1;
          w_next = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (w_at_target) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Targets are sampled only at load; later input changes wait for the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tgt_num   <= '0;
      r_tgt_shade <= '0;
    end else if (w_load) begin
      r_tgt_num   <= sat_count(target_num);
      r_tgt_shade <= target_shade;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_shade <= '0;
    end else if (w_step) begin
      if (r_count < r_tgt_num) begin
        r_count <= r_count + 1'b1;
      end else if (r_count > r_tgt_num) begin
        r_count <= r_count - 1'b1;
      end
      if (r_shade < r_tgt_shade) begin
        r_shade <= r_shade + 1'b1;
      end else if (r_shade > r_tgt_shade) begin
        r_shade <= r_shade - 1'b1;
      end
    end
  end

  // A fresh legal tcode event wins over the clear from a same-edge load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending   <= 1'b0;
      r_tcode_q   <= 4'b0000;
      r_tcode_err <= 1'b0;
      r_ack       <= 1'b0;
    end else begin
      r_tcode_q   <= tcode;
      r_tcode_err <= !w_tcode_legal;
      r_ack       <= w_load && upd_req;
      if (w_tcode_chg && w_tcode_legal) begin
        r_pending <= 1'b1;
      end else if (w_load) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign upd_ack    = r_ack;
  assign lightstate = therm(r_count);
  assign shade_pos  = r_shade;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign tcode_err  = r_tcode_err;

endmodule

`default_nettype wire
